// File: rtl/rr_arbiter4_if.sv
// Handshake bundle between the requesters and the round-robin arbiter.
// master = requester side (drives req/done); slave = arbiter side.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. The winner is presented as a binary
// index plus valid strobe, feeding the select input of a 2-to-4 decoder.
// A grant lasts until the owner releases (done or request drop) or until
// HOLD_MAX cycles have elapsed, after which the pointer moves past the owner.
module rr_arbiter4 #(
    parameter int unsigned HOLD_MAX = 15   // legal range 1..255
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter4_if.slave  bus
);
    localparam int NUM_REQ = 4;
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hcnt;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       rel_c;
    logic       frc_c;

    // Rotating priority scan: first set request at ptr, ptr+1, ... mod 4.
    // Scanning from the far end down lets the nearest hit overwrite the rest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner-driven release beats the hold limit when both land together.
    always_comb begin
        rel_c = bus.done || !bus.req[bus.gnt_idx];
        frc_c = !rel_c && (hcnt == HOLD_LIM);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 2'd0;
            hcnt          <= 8'd0;
            bus.gnt_idx   <= 2'd0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.gnt_idx   <= win_idx;
                        bus.gnt_valid <= 1'b1;
                        hcnt          <= 8'd1;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_c || frc_c) begin
                        bus.gnt_valid <= 1'b0;
                        bus.timeout   <= frc_c;
                        ptr           <= bus.gnt_idx + 2'd1;
                        state         <= IDLE;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.gnt_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: table of per-edge vectors for a default
// HOLD_MAX=15 instance (A) and a HOLD_MAX=4 instance (B), plus hand-written
// multi-cycle sequences around the hold limit.
module tb_rr_arbiter4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    rr_arbiter4_if a_if ();
    rr_arbiter4_if b_if ();

    rr_arbiter4 #(.HOLD_MAX(15)) u_dut_a (.clk(clk), .rst_n(rst_a), .bus(a_if));
    rr_arbiter4 #(.HOLD_MAX(4))  u_dut_b (.clk(clk), .rst_n(rst_b), .bus(b_if));

    typedef struct {
        logic       sel;    // 0 = instance A, 1 = instance B
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic [1:0] idx;    // expected outputs after the edge
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(logic sel, logic rst_n, logic [3:0] req, logic done,
                                logic [1:0] idx, logic vld, logic to);
        vec_t v;
        v.sel = sel; v.rst_n = rst_n; v.req = req; v.done = done;
        v.idx = idx; v.vld = vld; v.to = to;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {idx,vld,to}=%b want %b", name, act, exp);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs_a();
        return {a_if.gnt_idx, a_if.gnt_valid, a_if.timeout};
    endfunction

    function automatic logic [3:0] outs_b();
        return {b_if.gnt_idx, b_if.gnt_valid, b_if.timeout};
    endfunction

    initial begin
        int nv, nto, run, maxrun, ovl;
        rst_a = 1'b0; rst_b = 1'b0;
        a_if.req = 4'b0; a_if.done = 1'b0;
        b_if.req = 4'b0; b_if.done = 1'b0;

        // ---- Instance A (HOLD_MAX=15) ----
        // reset with everything requesting and done high
        add(0, 0, 4'b1111, 1, 2'd0, 0, 0);
        add(0, 0, 4'b1111, 1, 2'd0, 0, 0);
        // full rotation 0,1,2,3,0: three valid cycles, done on the third
        for (int g = 0; g < 5; g++) begin
            add(0, 1, 4'b1111, 0, 2'(g % 4), 1, 0);
            add(0, 1, 4'b1111, 0, 2'(g % 4), 1, 0);
            add(0, 1, 4'b1111, 0, 2'(g % 4), 1, 0);
            add(0, 1, 4'b1111, 1, 2'(g % 4), 0, 0);
        end
        // single requester 2: five valid cycles, done on the fifth
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0100, 1, 2'd2, 0, 0);
        // re-grant after one idle cycle, then release by request drop
        add(0, 1, 4'b0100, 0, 2'd2, 1, 0);
        add(0, 1, 4'b0000, 0, 2'd2, 0, 0);
        // done while idle ignored, index holds
        add(0, 1, 4'b0000, 1, 2'd2, 0, 0);
        // ptr=3: owner 3, non-owner request changes have no effect
        add(0, 1, 4'b1000, 0, 2'd3, 1, 0);
        add(0, 1, 4'b1111, 0, 2'd3, 1, 0);
        // reset on grant cycle 2, then req 1001 goes to 0 not 3
        add(0, 0, 4'b1001, 0, 2'd0, 0, 0);
        add(0, 1, 4'b1001, 0, 2'd0, 1, 0);
        add(0, 1, 4'b1001, 1, 2'd0, 0, 0);
        // request dropped while idle is forgotten; ptr=1 scans 1,2,3 -> 3
        add(0, 1, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 4'b1001, 0, 2'd3, 1, 0);
        add(0, 1, 4'b0000, 0, 2'd3, 0, 0);

        // ---- Instance B (HOLD_MAX=4) ----
        add(1, 0, 4'b0000, 0, 2'd0, 0, 0);
        // forced release after exactly 4 valid cycles
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 0, 1);
        // scan from ptr=2 wraps to 1; timeout lasted one cycle
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        // done in the limit cycle: plain release
        add(1, 1, 4'b0010, 1, 2'd1, 0, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        add(1, 1, 4'b0010, 0, 2'd1, 1, 0);
        // request drop in the limit cycle: plain release
        add(1, 1, 4'b0000, 0, 2'd1, 0, 0);
        add(1, 1, 4'b0000, 0, 2'd1, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].sel == 1'b0) begin
                rst_a = tbl[i].rst_n; a_if.req = tbl[i].req; a_if.done = tbl[i].done;
            end else begin
                rst_b = tbl[i].rst_n; b_if.req = tbl[i].req; b_if.done = tbl[i].done;
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), tbl[i].sel ? outs_b() : outs_a(),
                {tbl[i].idx, tbl[i].vld, tbl[i].to});
        end

        // ---- B: continuous single request, repeated forced releases ----
        rst_b = 1'b0; b_if.req = 4'b0; b_if.done = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1; b_if.req = 4'b0001;
        nv = 0; nto = 0; run = 0; maxrun = 0; ovl = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (b_if.gnt_valid) begin nv++; run++; end else run = 0;
            if (run > maxrun) maxrun = run;
            if (b_if.timeout) nto++;
            if (b_if.timeout && b_if.gnt_valid) ovl++;
        end
        chk_i("loop_valid_cycles", nv, 10);
        chk_i("loop_timeout_pulses", nto, 2);
        chk_i("loop_max_grant_len", maxrun, 4);
        chk_i("loop_timeout_with_valid", ovl, 0);

        // ---- B: reset on the edge where the limit would force ----
        rst_b = 1'b0; b_if.req = 4'b0; @(posedge clk); #1;
        rst_b = 1'b1; b_if.req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_limit_grant", outs_b(), {2'd2, 1'b1, 1'b0});
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("reset_at_limit", outs_b(), 4'b0000);
        rst_b = 1'b1; b_if.req = 4'b0101;
        @(posedge clk); #1;
        chk("after_reset_grant", outs_b(), {2'd0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
